// File: rtl/idma_stream_fifo_arb.sv
// idma_stream_fifo_arb
// Round-robin arbiter that feeds several bursty requesters into one
// downstream stream FIFO push port, keeping ownership for a whole burst
// (until the beat flagged last) and tracking the FIFO fill level so that
// no new burst is started once the almost-full watermark is reached.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset
//   flush_i        synchronous clear, issued together with the FIFO flush
//   inp_data_i     requester payloads, requester k at slice k
//   inp_valid_i    requester valid
//   inp_last_i     requester last beat of burst
//   inp_ready_o    requester ready (push_ready_i of the granted requester)
//   push_data_o    payload to the FIFO push side (0 when nothing granted)
//   push_valid_o   push valid
//   push_ready_i   FIFO push ready
//   pop_i          FIFO output handshake
//   grant_o        one-hot current grant, zero if none
//   locked_o       burst in progress
//   occupancy_o    tracked FIFO fill level
//   almost_full_o  occupancy_o >= AfThresh
module idma_stream_fifo_arb #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AfThresh  = Depth - 2,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NumInp*DataWidth-1:0]   inp_data_i,
  input  logic [NumInp-1:0]             inp_valid_i,
  input  logic [NumInp-1:0]             inp_last_i,
  output logic [NumInp-1:0]             inp_ready_o,
  output logic [DataWidth-1:0]          push_data_o,
  output logic                          push_valid_o,
  input  logic                          push_ready_i,
  input  logic                          pop_i,
  output logic [NumInp-1:0]             grant_o,
  output logic                          locked_o,
  output logic [CntWidth-1:0]           occupancy_o,
  output logic                          almost_full_o
);

  localparam int unsigned PtrWidth = $clog2(NumInp);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PtrWidth-1:0] rr_q, rr_d;
  logic [PtrWidth-1:0] owner_q, owner_d;
  logic [CntWidth-1:0] occ_q, occ_d;

  logic [DataWidth-1:0] inp_data [NumInp];
  logic                 arb_found;
  logic [PtrWidth-1:0]  arb_idx;
  logic                 gnt_any;
  logic [PtrWidth-1:0]  gnt_idx;
  logic                 xfer;
  logic                 clear;

  for (genvar k = 0; k < NumInp; k++) begin : g_unpack
    assign inp_data[k] = inp_data_i[k*DataWidth +: DataWidth];
  end

  assign clear         = rst_i | flush_i;
  assign almost_full_o = (occ_q >= CntWidth'(AfThresh));
  assign occupancy_o   = occ_q;
  assign locked_o      = (state_q == LOCKED);

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int unsigned cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      cand = (32'(rr_q) + i) % NumInp;
      if (!arb_found && inp_valid_i[PtrWidth'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = PtrWidth'(cand);
      end
    end
  end

  // Grant is suppressed during reset/flush so that no beat can complete
  // in a clearing cycle.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!clear) begin
      if (state_q == LOCKED) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end else if (!almost_full_o) begin
        gnt_any = arb_found;
        gnt_idx = arb_idx;
      end
    end
  end

  always_comb begin
    grant_o      = gnt_any ? (NumInp'(1) << gnt_idx) : '0;
    push_valid_o = gnt_any & inp_valid_i[gnt_idx];
    push_data_o  = gnt_any ? inp_data[gnt_idx] : '0;
    inp_ready_o  = push_ready_i ? grant_o : '0;
    xfer         = push_valid_o & push_ready_i;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    occ_d   = occ_q;
    if (xfer) begin
      if (inp_last_i[gnt_idx]) begin
        state_d = IDLE;
        rr_d    = (gnt_idx == PtrWidth'(NumInp - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        state_d = LOCKED;
        owner_d = gnt_idx;
      end
    end
    if (xfer && !pop_i && occ_q != CntWidth'(Depth)) begin
      occ_d = occ_q + 1'b1;
    end else if (pop_i && !xfer && occ_q != '0) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      occ_q   <= occ_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!clear) begin
      assert (!(xfer && !pop_i && occ_q == CntWidth'(Depth)))
        else $error("transfer into full FIFO");
      assert (!(pop_i && !xfer && occ_q == '0))
        else $error("pop from empty FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_idma_stream_fifo_arb.sv
module tb_idma_stream_fifo_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int CW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst, flush, pready, pop;
  logic [N*W-1:0] data;
  logic [N-1:0]   valid, last;
  logic [N-1:0]   inp_ready, grant;
  logic [W-1:0]   push_data;
  logic           push_valid, locked, af;
  logic [CW-1:0]  occ;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state: owner index (-1 = none), pointer, fill level.
  int m_owner, m_rr, m_occ, m_g;

  always #5 clk = ~clk;

  idma_stream_fifo_arb #(
    .NumInp   (N),
    .Depth    (D),
    .DataWidth(W),
    .AfThresh (AF)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .inp_data_i   (data),
    .inp_valid_i  (valid),
    .inp_last_i   (last),
    .inp_ready_o  (inp_ready),
    .push_data_o  (push_data),
    .push_valid_o (push_valid),
    .push_ready_i (pready),
    .pop_i        (pop),
    .grant_o      (grant),
    .locked_o     (locked),
    .occupancy_o  (occ),
    .almost_full_o(af)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge: let inputs settle, derive the expected
  // outputs from the model, compare every output.
  task automatic settle_check();
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    logic         ev;
    #1;
    m_g = -1;
    if (!(rst || flush)) begin
      if (m_owner >= 0) m_g = m_owner;
      else if (m_occ < AF) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (m_g < 0 && valid[c]) m_g = c;
        end
      end
    end
    eg = '0;
    ed = '0;
    ev = 1'b0;
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      ed = data[m_g*W +: W];
      ev = valid[m_g];
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("push_valid", 32'(push_valid), 32'(ev));
    chk("push_data", push_data, ed);
    chk("inp_ready", 32'(inp_ready), pready ? 32'(eg) : 32'd0);
    chk("locked", 32'(locked), 32'(m_owner >= 0));
    chk("occupancy", 32'(occ), 32'(m_occ));
    chk("almost_full", 32'(af), 32'(m_occ >= AF));
  endtask

  task automatic advance();
    bit xf;
    @(posedge clk);
    if (rst || flush) begin
      m_owner = -1;
      m_rr    = 0;
      m_occ   = 0;
    end else begin
      xf = (m_g >= 0) && valid[m_g] && pready;
      if (xf) begin
        if (last[m_g]) begin
          m_owner = -1;
          m_rr    = (m_g + 1) % N;
        end else begin
          m_owner = m_g;
        end
      end
      m_occ = m_occ + (xf ? 1 : 0) - (pop ? 1 : 0);
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) data[k*W +: W] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; valid = '0; last = '0; pop = 1'b0; pready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    m_owner = -1; m_rr = 0; m_occ = 0; m_g = -1;
    rst = 1'b1; flush = 1'b0; valid = '0; last = '0; pop = 1'b0; pready = 1'b0;
    data = '0;
    @(negedge clk);

    // Reset state
    settle_check();
    advance();
    rst = 1'b0;
    settle_check();
    chk("reset_occ", 32'(occ), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_af", 32'(af), 0);
    advance();

    // Round robin over all-valid single-beat requesters
    do_reset();
    valid = 4'hf; last = 4'hf; pready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      settle_check();
      chk("rr_grant", 32'(grant), 32'(1) << (i % 4));
      chk("rr_occ", 32'(occ), 32'(i));
      advance();
    end

    // Requester 2 holds a 3-beat burst while 0,1,3 stay valid
    do_reset();
    valid = 4'b0011; last = 4'hf;
    step(); step();
    valid = 4'hf; last = 4'b1011;
    settle_check(); chk("burst_g1", 32'(grant), 32'h4); chk("burst_l1", 32'(locked), 0); advance();
    settle_check(); chk("burst_g2", 32'(grant), 32'h4); chk("burst_l2", 32'(locked), 1); advance();
    last = 4'hf;
    settle_check(); chk("burst_g3", 32'(grant), 32'h4); chk("burst_l3", 32'(locked), 1); advance();
    settle_check(); chk("burst_next", 32'(grant), 32'h8); chk("burst_l4", 32'(locked), 0); advance();

    // Almost-full blocks new bursts but not the one in progress
    do_reset();
    valid = 4'b0001; last = 4'hf;
    repeat (5) step();
    valid = 4'b0010; last = 4'h0;
    step();
    valid = 4'hf;
    settle_check(); chk("af_set", 32'(af), 1); chk("af_burst", 32'(grant), 32'h2); advance();
    last = 4'hf;
    settle_check(); chk("af_last", 32'(grant), 32'h2); advance();
    settle_check(); chk("af_nogrant", 32'(grant), 0); chk("af_nopv", 32'(push_valid), 0);
    chk("af_full", 32'(occ), 8); advance();
    valid = '0; pop = 1'b1;
    repeat (3) step();
    valid = 4'b0001; last = 4'hf;
    settle_check(); chk("xp_before", 32'(occ), 5); advance();
    valid = '0;
    settle_check(); chk("xp_hold", 32'(occ), 5); advance();
    repeat (3) step();
    settle_check(); chk("pop_at1", 32'(occ), 1); advance();
    pop = 1'b0;
    settle_check(); chk("pop_to0", 32'(occ), 0); advance();

    // Flush in the middle of a burst
    do_reset();
    valid = 4'b0001; last = 4'hf;
    repeat (3) step();
    valid = 4'b0100; last = 4'h0;
    step();
    flush = 1'b1; valid = 4'hf;
    settle_check(); chk("fl_grant", 32'(grant), 0); chk("fl_ready", 32'(inp_ready), 0);
    chk("fl_pv", 32'(push_valid), 0); chk("fl_occ", 32'(occ), 4); advance();
    flush = 1'b0; valid = 4'b0110; last = 4'hf;
    settle_check(); chk("fl_unlock", 32'(locked), 0); chk("fl_occ0", 32'(occ), 0);
    chk("fl_lowest", 32'(grant), 32'h2); advance();

    // Backpressure holds grant, pointer and occupancy
    pready = 1'b0; valid = 4'b0100;
    settle_check(); chk("bp_grant", 32'(grant), 32'h4); chk("bp_ready", 32'(inp_ready), 0); advance();
    settle_check(); chk("bp_grant2", 32'(grant), 32'h4); chk("bp_occ", 32'(occ), 1); advance();
    pready = 1'b1; valid = 4'hf;
    step();
    settle_check(); chk("bp_after", 32'(grant), 32'h8); advance();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int pop_pct;
      pop_pct = ((i / 500) % 2 == 0) ? 20 : 60;
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 79) == 0);
      valid = N'($urandom);
      for (int k = 0; k < N; k++) last[k] = ($urandom_range(0, 2) == 0);
      rand_data();
      pop    = (m_occ > 0) && ($urandom_range(0, 99) < pop_pct);
      pready = (m_occ < D) && ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
